need_update_scheduler: RTL
==========================

# need_update_scheduler

Sequences all writes into the pet's need-value datapath (food, sleep, fun, happy). It collects user action requests (feed, rest, play, heal) and periodic decay events, then issues one update at a time through a valid/ready port. It applies a per-action cooldown and round-robin fairness among actions. It sits between the button/sensor front end and the needs register file, and replaces ad-hoc up/down strobes.

## Interface
- CLK_FREQ, 50000000, clock cycles per second; sec_tick period
- COOLDOWN_S, 3, seconds an action is locked after its update transfers; range 1..15
- DECAY_FOOD, 30, seconds between food decay events; range 1..127
- DECAY_SLEEP, 31, seconds between sleep decay events; range 1..127
- DECAY_FUN, 25, seconds between fun decay events; range 1..127
- DECAY_HAPPY, 23, seconds between happy decay events; range 1..127
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- req  in  4  level action requests, active-high, already synchronized; bit0 feed, bit1 rest, bit2 play, bit3 heal (heal targets the health path; need index 4)
- test_mode  in  1  freezes decay counters and suppresses new decay events
- upd_ready  in  1  datapath accepts the update this cycle
- upd_valid  out  1  update offered
- upd_need  out  3  need index: 0 food, 1 sleep, 2 fun, 3 happy, 4 health
- upd_dir  out  1  1 = increment (action), 0 = decrement (decay)
- cooldown_active  out  4  per-action lock, same bit order as req
- pending  out  8  [3:0] action pending, [7:4] decay pending (food..happy)
- sec_tick  out  1  one-cycle pulse each second

## Operation
- Reset values: every output is 0. All counters, pending bits and the RR pointer are cleared, and the FSM goes to IDLE.
- Edge detect: a rising edge is `req & ~req_q`. An edge on action k sets `pending[k]` unless `cooldown_active[k]`; if locked, the edge is dropped. An edge while already pending coalesces into the existing pending bit.
- Decay: each need has a 7-bit second counter, incremented on sec_tick.
  - When the counter reaches its DECAY_x value, the counter resets to 0 and the corresponding decay pending bit is set; a duplicate coalesces.
  - While test_mode=1, the counters hold and no new decay pending bits are set. Existing decay pending bits are still served.
- FSM has two states, IDLE and ISSUE.
  - IDLE: if any grantable action is pending (pending and not locked), choose it by round-robin, starting at the RR pointer and searching upward mod 4. Otherwise, if any decay is pending, choose the lowest index.
  - On choosing: register upd_valid=1, upd_need and upd_dir, clear the chosen pending bit, and go to ISSUE.
  - ISSUE: hold upd_valid, upd_need and upd_dir stable until upd_valid && upd_ready. On that edge, deassert upd_valid and return to IDLE.
  - Action transfer extras: load that action's cooldown counter with COOLDOWN_S, and set the RR pointer to k+1 mod 4.
- Cooldown: decrements on sec_tick and saturates at 0. `cooldown_active[k]` = (counter != 0).
- Actions always outrank decay. Decay is never starved indefinitely because cooldown bounds the action rate.

## Timing
- Request rising edge sampled at edge E0 → pending set after E0 → upd_valid high after E1. Minimum latency is 2 cycles.
- There is at least one IDLE cycle between transfers. Peak throughput is one update per 2 cycles.
- sec_tick is high for the cycle in which the divider wraps from CLK_FREQ-1 to 0.
- Simultaneous events:
  - Edge on k in the same cycle as the grant of k: the pending bit clears and the edge is ignored, because the action locks at transfer.
  - Decay event in the cycle its pending bit is granted: the pending bit stays set.
  - sec_tick in the cycle a cooldown is loaded: the load wins.
- rst mid-ISSUE: upd_valid drops on the next edge and the update is discarded.

## Structure
- Shared package holds:
  - need index constants NEED_FOOD..NEED_HEALTH
  - action bit constants ACT_FEED..ACT_HEAL
  - UPD_UP and UPD_DOWN
  - state encoding IDLE/ISSUE
- One sub-module, `sec_tick_gen`: a CLK_FREQ divider producing sec_tick, with synchronous active-high reset. It is shared with the face/visual logic.

## Test plan
Parameters for all scenarios: CLK_FREQ=10, COOLDOWN_S=2, DECAY_FOOD=3, other decays 100.

- Reset: assert rst for 3 cycles → all outputs 0. The first food decay (upd_need=0, dir=0) appears 30 cycles after release, plus 1–2 cycles of latency.
- Feed press: req[0] 0→1 with upd_ready=1 → upd_valid for one cycle, 2 cycles after the edge, with need=0 and dir=1. cooldown_active[0] stays high for 20 cycles, and re-presses during that window produce no update.
- Backpressure: upd_ready=0 for 5 cycles during ISSUE → upd_valid, upd_need and upd_dir stay stable. A single transfer occurs on the cycle upd_ready rises.
- Fairness: req[3:0] all rise together with upd_ready=1 → grants in order feed, rest, play, heal (need 0,1,2,4), spaced 2 cycles apart.
- Priority and coalescing: a food decay is pending while feed is pending → the feed update transfers first, then the decay. Two decay periods elapsing with upd_ready=0 yield exactly one decay transfer.
- test_mode=1 for 50 cycles → no decay updates issue; actions still issue normally.

Source files
------------

// File: rtl/need_update_scheduler_pkg.sv
// Shared constants for the need-update path: need indices, action bits, direction, FSM states.
// Also holds the round-robin picker used to choose among pending actions.
package need_update_scheduler_pkg;

    localparam logic [2:0] NEED_FOOD   = 3'd0;
    localparam logic [2:0] NEED_SLEEP  = 3'd1;
    localparam logic [2:0] NEED_FUN    = 3'd2;
    localparam logic [2:0] NEED_HAPPY  = 3'd3;
    localparam logic [2:0] NEED_HEALTH = 3'd4;

    localparam int ACT_FEED = 0;
    localparam int ACT_REST = 1;
    localparam int ACT_PLAY = 2;
    localparam int ACT_HEAL = 3;

    localparam logic UPD_UP   = 1'b1;
    localparam logic UPD_DOWN = 1'b0;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } pick_t;

    // Nearest set bit at or above ptr, wrapping mod 4.
    function automatic pick_t rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
        pick_t      p;
        logic [1:0] idx;
        p = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (mask[idx]) begin
                p.hit = 1'b1;
                p.idx = idx;
            end
        end
        return p;
    endfunction

    function automatic logic [2:0] act_to_need(input logic [1:0] act);
        return (act == 2'(ACT_HEAL)) ? NEED_HEALTH : {1'b0, act};
    endfunction

endpackage

// File: rtl/need_update_scheduler_if.sv
// Update port toward the needs register file: one need index plus direction per transfer.
// Transfer happens when upd_valid && upd_ready; master holds the payload stable until then.
interface need_update_scheduler_if;
    logic       upd_valid;
    logic       upd_ready;
    logic [2:0] upd_need;
    logic       upd_dir;

    modport master (output upd_valid, output upd_need, output upd_dir, input  upd_ready);
    modport slave  (input  upd_valid, input  upd_need, input  upd_dir, output upd_ready);
endinterface

// File: rtl/need_update_scheduler_sec_tick_gen.sv
// Divides clk by CLK_FREQ; sec_tick is high for the cycle the divider wraps to 0.
// Free-running, no backpressure; shared with the face/visual logic.
module sec_tick_gen #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic clk,
    input  logic rst,
    output logic sec_tick
);
    localparam int            CW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sec_tick = (cnt_q == LAST);
endmodule

// File: rtl/need_update_scheduler.sv
// Serialises action requests and periodic decay into one need update at a time, with cooldown and RR.
// Latency: req edge to upd_valid is 2 cycles; backpressure: payload held in ISSUE until upd_ready.
module need_update_scheduler
    import need_update_scheduler_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int COOLDOWN_S  = 3,
    parameter int DECAY_FOOD  = 30,
    parameter int DECAY_SLEEP = 31,
    parameter int DECAY_FUN   = 25,
    parameter int DECAY_HAPPY = 23
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    req,
    input  logic                          test_mode,
    need_update_scheduler_if.master       upd,
    output logic [3:0]                    cooldown_active,
    output logic [7:0]                    pending,
    output logic                          sec_tick
);
    localparam logic [3:0]      CD_LOAD    = 4'(COOLDOWN_S);
    localparam logic [3:0][6:0] DECAY_LAST = {7'(DECAY_HAPPY - 1), 7'(DECAY_FUN - 1),
                                              7'(DECAY_SLEEP - 1), 7'(DECAY_FOOD - 1)};

    logic [3:0]      req_q;
    logic [7:0]      pend_q, pend_d;
    logic [3:0][3:0] cd_q, cd_d;
    logic [3:0][6:0] dcnt_q, dcnt_d;
    logic [1:0]      rr_q, rr_d;
    logic [0:0]      state_q, state_d;
    logic            vld_q, vld_d;
    logic [2:0]      need_q, need_d;
    logic            dir_q, dir_d;

    logic [3:0] act_set, act_clr, dec_set, dec_clr;
    logic [1:0] dec_idx, xfer_act;
    logic       xfer;
    pick_t      act_pick;

    sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_sec_tick (
        .clk      (clk),
        .rst      (rst),
        .sec_tick (sec_tick)
    );

    always_comb begin
        cooldown_active = '0;
        for (int k = 0; k < 4; k++) cooldown_active[k] = (cd_q[k] != 4'd0);
    end

    assign xfer     = (state_q == ISSUE) && upd.upd_ready;
    assign xfer_act = (need_q == NEED_HEALTH) ? 2'(ACT_HEAL) : need_q[1:0];
    assign act_pick = rr_pick(pend_q[3:0] & ~cooldown_active, rr_q);
    assign act_set  = req & ~req_q & ~cooldown_active;

    always_comb begin
        dec_idx = 2'd0;
        for (int k = 3; k >= 0; k--) if (pend_q[4+k]) dec_idx = 2'(k);
    end

    // Decay second counters freeze entirely in test_mode.
    always_comb begin
        dcnt_d  = dcnt_q;
        dec_set = '0;
        if (sec_tick && !test_mode) begin
            for (int k = 0; k < 4; k++) begin
                if (dcnt_q[k] == DECAY_LAST[k]) begin
                    dcnt_d[k]  = '0;
                    dec_set[k] = 1'b1;
                end else begin
                    dcnt_d[k] = dcnt_q[k] + 7'd1;
                end
            end
        end
    end

    always_comb begin
        cd_d = cd_q;
        for (int k = 0; k < 4; k++) begin
            if (xfer && dir_q == UPD_UP && xfer_act == 2'(k)) cd_d[k] = CD_LOAD;
            else if (sec_tick && cd_q[k] != 4'd0)           cd_d[k] = cd_q[k] - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        need_d  = need_q;
        dir_d   = dir_q;
        rr_d    = rr_q;
        act_clr = '0;
        dec_clr = '0;
        if (state_q == IDLE) begin
            if (act_pick.hit) begin
                vld_d                 = 1'b1;
                need_d                = act_to_need(act_pick.idx);
                dir_d                 = UPD_UP;
                act_clr[act_pick.idx] = 1'b1;
                state_d               = ISSUE;
            end else if (pend_q[7:4] != 4'd0) begin
                vld_d            = 1'b1;
                need_d           = {1'b0, dec_idx};
                dir_d            = UPD_DOWN;
                dec_clr[dec_idx] = 1'b1;
                state_d          = ISSUE;
            end
        end else if (upd.upd_ready) begin
            vld_d   = 1'b0;
            state_d = IDLE;
            if (dir_q == UPD_UP) rr_d = xfer_act + 2'd1;
        end
    end

    // Grant beats a same-cycle action edge; a same-cycle decay event beats its grant.
    always_comb begin
        pend_d[3:0] = (pend_q[3:0] | act_set) & ~act_clr;
        pend_d[7:4] = (pend_q[7:4] & ~dec_clr) | dec_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            pend_q  <= '0;
            cd_q    <= '0;
            dcnt_q  <= '0;
            rr_q    <= '0;
            state_q <= IDLE;
            vld_q   <= 1'b0;
            need_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            req_q   <= req;
            pend_q  <= pend_d;
            cd_q    <= cd_d;
            dcnt_q  <= dcnt_d;
            rr_q    <= rr_d;
            state_q <= state_d;
            vld_q   <= vld_d;
            need_q  <= need_d;
            dir_q   <= dir_d;
        end
    end

    assign upd.upd_valid = vld_q;
    assign upd.upd_need  = need_q;
    assign upd.upd_dir   = dir_q;
    assign pending       = pend_q;
endmodule
